// File: rtl/spi_regif_slave.sv
// spi_regif_slave
//   SPI responder that turns 16-bit frames into register-file accesses.
//   Frame: command byte {rw, addr[3:0], 3'bxxx} then one data byte, MSB first.
//   sclk/ss/mosi are oversampled on clk; all decoding is done on detected sclk rises.
//   Write frames end in a one-clk wr_stb.
//   Read frames issue a one-clk rd_stb after the command byte and shift rd_data out on miso.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   sclk, ss, mosi     SPI inputs (sclk idles high, ss active-high)
//   miso, spioe        serial read data and its pad output enable
//   reg_addr           register address from the command byte
//   wr_stb, wr_data    write strobe and data
//   rd_stb, rd_data    read request and returned register data
//   xfer_err           one-clk pulse when ss drops mid-frame
//
// state | meaning
// IDLE  | waiting for ss; bit counter cleared
// CMD   | shifting in the command byte
// LOAD  | one clk to capture rd_data after rd_stb
// DATA  | shifting the data byte (and read data out)
// DONE  | frame finished; rises ignored until ss drops

module spi_regif_slave #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       spioe,
    output logic [3:0] reg_addr,
    output logic       wr_stb,
    output logic [7:0] wr_data,
    output logic       rd_stb,
    input  logic [7:0] rd_data,
    output logic       xfer_err
);

    typedef enum logic [2:0] {IDLE, CMD, LOAD, DATA, DONE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_d;
    logic       sclk_s, ss_s, mosi_s;
    logic       rise;
    logic [3:0] bitcnt;
    logic [7:0] sr, tx;
    logic [7:0] shift_in;
    logic       rw;
    logic       rd_go, wr_go, err_go;

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_d;
    assign shift_in = {sr[6:0], mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_go      = 1'b0;
        wr_go      = 1'b0;
        err_go     = 1'b0;
        case (state)
            IDLE: if (ss_s) state_next = CMD;
            CMD: begin
                if (!ss_s) begin
                    err_go     = 1'b1;
                    state_next = IDLE;
                end else if (rise && bitcnt == 4'd7) begin
                    if (shift_in[7]) begin
                        rd_go      = 1'b1;
                        state_next = LOAD;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            LOAD: begin
                if (!ss_s) begin
                    err_go     = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = DATA;
                end
            end
            DATA: begin
                // the final rise completes the frame even if ss drops in the same clk
                if (rise && bitcnt == 4'd15) begin
                    wr_go      = ~rw;
                    state_next = DONE;
                end else if (!ss_s) begin
                    err_go     = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE: if (!ss_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miso     <= IDLE_MISO;
            spioe    <= 1'b0;
            reg_addr <= 4'h0;
            wr_stb   <= 1'b0;
            wr_data  <= 8'h00;
            rd_stb   <= 1'b0;
            xfer_err <= 1'b0;
            bitcnt   <= 4'd0;
            sr       <= 8'h00;
            tx       <= 8'h00;
            rw       <= 1'b0;
        end else begin
            rd_stb   <= rd_go;
            wr_stb   <= wr_go;
            xfer_err <= err_go;
            spioe    <= (state_next == LOAD) || (state_next == DATA);
            case (state)
                CMD: begin
                    if (ss_s && rise) begin
                        sr     <= shift_in;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            reg_addr <= shift_in[6:3];
                            rw       <= shift_in[7];
                        end
                    end
                end
                LOAD: begin
                    if (ss_s) begin
                        tx   <= rd_data;
                        miso <= rd_data[7];
                    end
                end
                DATA: begin
                    if (rise && (ss_s || bitcnt == 4'd15)) begin
                        sr     <= shift_in;
                        bitcnt <= bitcnt + 4'd1;
                        if (rw) begin
                            tx   <= tx << 1;
                            miso <= tx[6];
                        end else if (bitcnt == 4'd15) begin
                            wr_data <= shift_in;
                        end
                    end
                end
                default: ;
            endcase
            // leaving the data phase (done or aborted) always parks miso
            if (state_next == IDLE || state_next == DONE) miso <= IDLE_MISO;
            if (state_next == IDLE) bitcnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_spi_regif_slave.sv
module tb_spi_regif_slave;

    localparam logic IDLE_MISO = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk, ss, mosi;
    logic       miso, spioe;
    logic [3:0] reg_addr;
    logic       wr_stb, rd_stb, xfer_err;
    logic [7:0] wr_data, rd_data;

    int total = 0;
    int bad   = 0;

    spi_regif_slave #(.SYNC_STAGES(2), .IDLE_MISO(IDLE_MISO)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .spioe(spioe), .reg_addr(reg_addr),
        .wr_stb(wr_stb), .wr_data(wr_data), .rd_stb(rd_stb),
        .rd_data(rd_data), .xfer_err(xfer_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [3:0] addr;
        logic [2:0] low;
        logic [7:0] data;
    } frame_t;

    // kind: 0 = write strobe, 1 = read strobe, 2 = transfer error
    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t evq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [3:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        evq.push_back(e);
    endtask

    // strobe scoreboard
    always @(negedge clk) begin
        ev_t e;
        if (wr_stb || rd_stb || xfer_err) begin
            if (evq.size() == 0) begin
                check("unexpected_event", 32'({wr_stb, rd_stb, xfer_err}), 32'd0);
            end else begin
                e = evq.pop_front();
                check("event_kind", 32'({wr_stb, rd_stb, xfer_err}),
                      (e.kind == 0) ? 32'd4 : (e.kind == 1) ? 32'd2 : 32'd1);
                if (wr_stb) begin
                    check("wr_addr", 32'(reg_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                end
                if (rd_stb) check("rd_addr", 32'(reg_addr), 32'(e.addr));
            end
        end
    end

    task automatic spi_xfer(input logic [15:0] word, input int nrise, input bit sel,
                            input bit drop_with_last, input bit keep_ss,
                            output logic [7:0] cap, output bit oe_ok, output bit idle_ok);
        cap     = 8'h00;
        oe_ok   = 1'b1;
        idle_ok = 1'b1;
        if (sel) ss = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            sclk = 1'b0;
            mosi = word[15-i];
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            if (drop_with_last && i == nrise - 1) ss = 1'b0;
            if (i >= 8) begin
                cap = {cap[6:0], miso};
                if (spioe !== 1'b1) oe_ok = 1'b0;
            end
            if (spioe !== 1'b0 || miso !== IDLE_MISO) idle_ok = 1'b0;
            repeat (2) @(negedge clk);
        end
        if (!keep_ss) ss = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        check(name, 32'({spioe, miso}), 32'({1'b0, IDLE_MISO}));
    endtask

    task automatic check_reset_vals(input string name);
        check(name, 32'({miso, spioe, reg_addr, wr_stb, wr_data, rd_stb, xfer_err}),
              32'({IDLE_MISO, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0}));
    endtask

    task automatic run_frame(input frame_t f, input bit drop_with_last);
        logic [7:0] cap;
        bit oe_ok, idle_ok;
        if (f.rw) begin
            rd_data = f.data;
            push_ev(1, f.addr, 8'h00);
        end else begin
            push_ev(0, f.addr, f.data);
        end
        spi_xfer({f.rw, f.addr, f.low, (f.rw ? 8'h00 : f.data)}, 16, 1'b1,
                 drop_with_last, 1'b0, cap, oe_ok, idle_ok);
        if (f.rw) check("read_capture", 32'(cap), 32'(f.data));
        check("spioe_data_phase", 32'(oe_ok), 32'd1);
        check_quiet("post_frame_idle");
    endtask

    frame_t tbl[6];

    initial begin
        logic [7:0] cap;
        bit oe_ok, idle_ok;
        frame_t f;

        tbl[0] = '{1'b0, 4'h2, 3'd0, 8'h5A};
        tbl[1] = '{1'b1, 4'h0, 3'd0, 8'hC3};
        tbl[2] = '{1'b0, 4'hF, 3'd0, 8'hFF};
        tbl[3] = '{1'b1, 4'hF, 3'd0, 8'h01};
        tbl[4] = '{1'b0, 4'hA, 3'd7, 8'h3C};
        tbl[5] = '{1'b1, 4'h5, 3'd5, 8'hA5};

        reset   = 1'b1;
        sclk    = 1'b1;
        ss      = 1'b0;
        mosi    = 1'b0;
        rd_data = 8'h00;
        repeat (4) @(negedge clk);
        check_reset_vals("reset_state");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(tbl[i], 1'b0);

        // ss dropped after 11 rises of a write, then a clean write
        push_ev(2, 4'h0, 8'h00);
        spi_xfer(16'h2877, 11, 1'b1, 1'b0, 1'b0, cap, oe_ok, idle_ok);
        check_quiet("abort_idle");
        f = '{1'b0, 4'h3, 3'd0, 8'h81};
        run_frame(f, 1'b0);

        // clock burst with ss low: nothing decoded
        spi_xfer(16'h8000, 16, 1'b0, 1'b0, 1'b0, cap, oe_ok, idle_ok);
        check("burst_ss_low_quiet", 32'(idle_ok), 32'd1);

        // ss drops in the same clk as the 16th rise: frame still completes
        f = '{1'b0, 4'h7, 3'd0, 8'h66};
        run_frame(f, 1'b1);

        // ss held high after a frame: a second burst must not decode
        push_ev(0, 4'h9, 8'h99);
        spi_xfer(16'h4899, 16, 1'b1, 1'b0, 1'b1, cap, oe_ok, idle_ok);
        spi_xfer(16'hB000, 16, 1'b1, 1'b0, 1'b0, cap, oe_ok, idle_ok);
        check("ss_held_no_second_frame", 32'(idle_ok), 32'd1);

        // reset after the 12th rise of a read
        rd_data = 8'h5E;
        push_ev(1, 4'h6, 8'h00);
        spi_xfer(16'hB000, 12, 1'b1, 1'b0, 1'b1, cap, oe_ok, idle_ok);
        reset = 1'b1;
        ss    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_mid_frame");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        f = '{1'b1, 4'h6, 3'd0, 8'h5E};
        run_frame(f, 1'b0);

        repeat (10) @(negedge clk);
        check("events_outstanding", 32'(evq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
